// File: rtl/adc16dv160_input_read_pkg.sv
// Shared constants for the ADC16DV160 input block: AXI register offsets,
// register bit positions, response codes and the read-channel FSM state type.
package adc16dv160_input_common;

  localparam logic [31:0] AXI_ADDR_CR           = 32'h00;
  localparam logic [31:0] AXI_ADDR_SR           = 32'h04;
  localparam logic [31:0] AXI_ADDR_DSIZE        = 32'h08;
  localparam logic [31:0] AXI_ADDR_LS_START_THR = 32'h0C;
  localparam logic [31:0] AXI_ADDR_LS_STOP_THR  = 32'h10;
  localparam logic [31:0] AXI_ADDR_LS_N_START   = 32'h14;
  localparam logic [31:0] AXI_ADDR_LS_N_STOP    = 32'h18;
  localparam logic [31:0] AXI_ADDR_SAMPLE_CNT   = 32'h1C;
  localparam logic [31:0] AXI_ADDR_ID           = 32'h20;

  localparam int CR_START = 0;
  localparam int CR_TEST  = 1;
  localparam int CR_RT    = 2;
  localparam int CR_LS    = 3;

  localparam int SR_BUSY = 0;
  localparam int SR_DONE = 1;
  localparam int SR_OVF  = 2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_DATA   = 2'd2
  } read_state_e;

endpackage

// File: rtl/adc16dv160_input_read_if.sv
// AXI4-Lite read address and read data channels of the input block.
// Handshake: a beat transfers on the rising ACLK edge where both VALID and
// READY are high; once VALID is raised, it and its payload hold until then.
interface adc16dv160_input_read_if;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  modport slave (
    input  ARADDR, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output ARADDR, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/adc16dv160_input_sticky.sv
// One-bit sticky flag: set by an event pulse, cleared on request, with set
// taking priority so an event coinciding with the clear is never lost.
module adc16dv160_input_sticky (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic set,
  input  logic clr,
  output logic q
);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end else if (clr) begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/adc16dv160_input_read.sv
// AXI4-Lite read responder for the ADC16DV160 input block: one read at a
// time, data snapshotted during the single ACCEPT cycle and held until RREADY.
module adc16dv160_input_read
  import adc16dv160_input_common::*;
#(
  parameter logic [31:0] ID_VALUE = 32'hAD16_0100,
  parameter int          ADDR_W   = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  adc16dv160_input_read_if.slave          axi,
  input  logic                            cr_test,
  input  logic                            cr_rt,
  input  logic                            cr_ls,
  input  logic [31:0]                     dsize,
  input  logic [15:0]                     ls_start_thr,
  input  logic [15:0]                     ls_stop_thr,
  input  logic [31:0]                     ls_n_start,
  input  logic [31:0]                     ls_n_stop,
  input  logic                            busy,
  input  logic                            done_evt,
  input  logic                            ovf_evt,
  input  logic [31:0]                     sample_cnt,
  output read_state_e                     state_dbg
);

  read_state_e state_q, state_d;
  logic        arready, rvalid;
  logic [31:0] offset;
  logic [31:0] rd_d;
  logic        rd_hit;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        done_q, ovf_q;
  logic        sr_clr;
  logic        unused_addr_hi;

  assign offset         = 32'(axi.ARADDR[ADDR_W-1:0]);
  assign unused_addr_hi = ^axi.ARADDR[31:ADDR_W];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (axi.ARVALID) state_d = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        arready = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        rvalid = 1'b1;
        if (axi.RREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Exact-offset decode: any unaligned byte address falls to the default arm.
  always_comb begin
    rd_d   = '0;
    rd_hit = 1'b1;
    case (offset)
      AXI_ADDR_CR: begin
        rd_d[CR_TEST] = cr_test;
        rd_d[CR_RT]   = cr_rt;
        rd_d[CR_LS]   = cr_ls;
      end
      AXI_ADDR_SR: begin
        rd_d[SR_BUSY] = busy;
        rd_d[SR_DONE] = done_q;
        rd_d[SR_OVF]  = ovf_q;
      end
      AXI_ADDR_DSIZE:        rd_d = dsize;
      AXI_ADDR_LS_START_THR: rd_d = 32'(ls_start_thr);
      AXI_ADDR_LS_STOP_THR:  rd_d = 32'(ls_stop_thr);
      AXI_ADDR_LS_N_START:   rd_d = ls_n_start;
      AXI_ADDR_LS_N_STOP:    rd_d = ls_n_stop;
      AXI_ADDR_SAMPLE_CNT:   rd_d = sample_cnt;
      AXI_ADDR_ID:           rd_d = ID_VALUE;
      default:               rd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= AXI_RESP_OKAY;
    end else if (state_q == ST_ACCEPT) begin
      rdata_q <= rd_hit ? rd_d : 32'h0;
      rresp_q <= rd_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end
  end

  // The clear lands on the same edge that snapshots SR, so the read sees the old value.
  assign sr_clr = (state_q == ST_ACCEPT) && (offset == AXI_ADDR_SR);

  adc16dv160_input_sticky u_done (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .set     (done_evt),
    .clr     (sr_clr),
    .q       (done_q)
  );

  adc16dv160_input_sticky u_ovf (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .set     (ovf_evt),
    .clr     (sr_clr),
    .q       (ovf_q)
  );

  assign axi.ARREADY = arready;
  assign axi.RVALID  = rvalid;
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = rresp_q;
  assign state_dbg   = state_q;

endmodule
